// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the data memory arbiter.
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // Owner identifiers for the two requesters
  localparam logic CPU = 1'b0;
  localparam logic DBG = 1'b1;

  // Debug accesses are always full words
  localparam logic [3:0] DBG_SIGN_MASK = 4'b0111;

  // Read data returned when the memory never completes the access
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/data_mem_arbiter_arb_pick2.sv
// Two-way arbitration pick for the data memory arbiter.
// req[0] is the CPU, req[1] is the debug port; grant is the winning owner id.
// DATA_MEM_ARB_RR_EN: when defined, a tie goes to the requester that was not
// served last; otherwise the CPU always wins a tie.
module arb_pick2
  import data_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       grant
);

`ifdef DATA_MEM_ARB_RR_EN
  // Alternate between requesters when both ask at once
  always_comb begin
    grant = CPU;
    if (req == 2'b11) begin
      grant = ~last_owner;
    end else if (req[1]) begin
      grant = DBG;
    end
  end
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  // Fixed priority: CPU first, debug only when the CPU is quiet
  always_comb begin
    grant = CPU;
    if (!req[0] && req[1]) begin
      grant = DBG;
    end
  end
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Data memory arbiter: shares a single-port data memory between the CPU
// load/store path and a debug/DMA port. One access at a time is latched,
// issued for one cycle and then held until the memory's clk_stall completes.
// Optional feature macro: DATA_MEM_ARB_RR_EN (round-robin tie breaking).
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int STALL_TO = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_memread,
  input  logic              cpu_memwrite,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [3:0]        cpu_sign_mask,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_sign_mask,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_clk_stall
);

  localparam int CNT_W = $clog2(STALL_TO + 1);

  arb_state_t       state;
  logic             owner;
  logic             acc_read;
  logic             seen_stall;
  logic [CNT_W-1:0] wait_cnt;
  logic             cpu_req;
  logic             pick;
  logic             pick_last;

  assign cpu_req = cpu_memread | cpu_memwrite;

`ifdef DATA_MEM_ARB_RR_EN
  logic last_owner;
  assign pick_last = last_owner;
`else
  assign pick_last = DBG;
`endif

  arb_pick2 u_pick (
    .req        ({dbg_req, cpu_req}),
    .last_owner (pick_last),
    .grant      (pick)
  );

  // The CPU is held off until the cycle its own access completes
  assign cpu_stall = cpu_req & ~((state == DONE) && (owner == CPU));

  // Access sequencer: arbitrate, issue one cycle, wait out the stall, complete
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      owner         <= CPU;
      acc_read      <= 1'b0;
      seen_stall    <= 1'b0;
      wait_cnt      <= '0;
      cpu_rdata     <= '0;
      dbg_gnt       <= 1'b0;
      dbg_rvalid    <= 1'b0;
      dbg_rdata     <= '0;
      mem_memread   <= 1'b0;
      mem_memwrite  <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_sign_mask <= 4'b0000;
`ifdef DATA_MEM_ARB_RR_EN
      last_owner    <= DBG;
`endif
    end else begin
      dbg_gnt      <= 1'b0;
      dbg_rvalid   <= 1'b0;
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req || dbg_req) begin
            owner      <= pick;
            seen_stall <= 1'b0;
            wait_cnt   <= '0;
            state      <= ISSUE;
            if (pick == DBG) begin
              acc_read      <= ~dbg_we;
              mem_memread   <= ~dbg_we;
              mem_memwrite  <= dbg_we;
              mem_addr      <= dbg_addr;
              mem_wdata     <= dbg_wdata;
              mem_sign_mask <= DBG_SIGN_MASK;
              dbg_gnt       <= 1'b1;
            end else begin
              acc_read      <= cpu_memread;
              mem_memread   <= cpu_memread;
              mem_memwrite  <= cpu_memwrite;
              mem_addr      <= cpu_addr;
              mem_wdata     <= cpu_wdata;
              mem_sign_mask <= cpu_sign_mask;
            end
          end
        end
        ISSUE: begin
          seen_stall <= mem_clk_stall;
          state      <= WAIT;
        end
        WAIT: begin
          if (mem_clk_stall) begin
            seen_stall <= 1'b1;
          end
          if (seen_stall && !mem_clk_stall) begin
            state <= DONE;
            if (owner == CPU) begin
              cpu_rdata <= mem_rdata;
            end else if (acc_read) begin
              dbg_rdata  <= mem_rdata;
              dbg_rvalid <= 1'b1;
            end
          end else if (wait_cnt >= CNT_W'(STALL_TO - 1)) begin
            state    <= DONE;
            wait_cnt <= CNT_W'(STALL_TO);
            if (owner == CPU) begin
              cpu_rdata <= DATA_W'(TIMEOUT_DATA);
            end else if (acc_read) begin
              dbg_rdata  <= DATA_W'(TIMEOUT_DATA);
              dbg_rvalid <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
`ifdef DATA_MEM_ARB_RR_EN
          last_owner <= owner;
`endif
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios followed by
// random CPU/debug traffic, checked by a monitor against a scoreboard filled
// from a word-level reference model of the shared memory.
module tb_data_mem_arbiter;

  localparam int STALL_TO = 15;

  logic        clk;
  logic        reset;
  logic        cpu_memread;
  logic        cpu_memwrite;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_sign_mask;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dbg_req;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        mem_memread;
  logic        mem_memwrite;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_rdata;
  logic        mem_clk_stall;

  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STALL_TO(STALL_TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_memread   (cpu_memread),
    .cpu_memwrite  (cpu_memwrite),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_sign_mask (cpu_sign_mask),
    .cpu_rdata     (cpu_rdata),
    .cpu_stall     (cpu_stall),
    .dbg_req       (dbg_req),
    .dbg_we        (dbg_we),
    .dbg_addr      (dbg_addr),
    .dbg_wdata     (dbg_wdata),
    .dbg_gnt       (dbg_gnt),
    .dbg_rvalid    (dbg_rvalid),
    .dbg_rdata     (dbg_rdata),
    .mem_memread   (mem_memread),
    .mem_memwrite  (mem_memwrite),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_sign_mask (mem_sign_mask),
    .mem_rdata     (mem_rdata),
    .mem_clk_stall (mem_clk_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int checks = 0;
  int failures = 0;

  // One comparison: count it and report a mismatch
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Scoreboard entries
  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    int          lat;
  } issue_t;
  typedef struct {
    logic        is_read;
    logic [31:0] rdata;
  } resp_t;

  issue_t      issue_q[$];
  resp_t       cpu_q[$];
  logic [31:0] dbg_q[$];

  function automatic logic [31:0] defaultWord(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  // Environment memory: a word store with a configurable stall length
  logic [31:0] env_mem [logic [31:0]];
  int          next_lat = 1;
  bit          dead = 1'b0;
  int          stall_left = 0;
  logic [31:0] env_rdata = 32'h0;

  function automatic logic [31:0] envRead(input logic [31:0] a);
    if (env_mem.exists(a)) return env_mem[a];
    return defaultWord(a);
  endfunction

  assign mem_clk_stall = !dead && ((mem_memread || mem_memwrite) || (stall_left > 0));
  assign mem_rdata     = env_rdata;

  always @(posedge clk) begin
    if (mem_memread || mem_memwrite) begin
      stall_left <= next_lat - 1;
      if (mem_memwrite) env_mem[mem_addr] = mem_wdata;
      else env_rdata <= envRead(mem_addr);
    end else if (stall_left > 0) begin
      stall_left <= stall_left - 1;
    end
  end

  // Reference model: what the shared memory holds and who was served last
  logic [31:0] model_mem [logic [31:0]];
  logic        model_last = 1'b1;

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return defaultWord(a);
  endfunction

  // Record one access in service order and the response it must produce
  task automatic modelServe(input bit is_dbg, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] mask, input bit no_resp);
    issue_t      e;
    logic [31:0] rd;
    e.rd    = !we;
    e.wr    = we;
    e.addr  = addr;
    e.wdata = wdata;
    e.mask  = is_dbg ? 4'b0111 : mask;
    e.lat   = dead ? STALL_TO + 1 : next_lat + 1;
    issue_q.push_back(e);
    rd = dead ? 32'hDEAD_BEEF : modelRead(addr);
    if (we) model_mem[addr] = wdata;
    if (!no_resp) begin
      if (!is_dbg) cpu_q.push_back('{is_read: !we, rdata: rd});
      else if (!we) dbg_q.push_back(rd);
    end
    model_last = is_dbg;
  endtask

  // Monitor: compare every DUT event against the scoreboard
  logic prev_issue = 1'b0;
  logic prev_gnt = 1'b0;
  int   issue_cycle = 0;
  int   cur_lat = 0;
  int   stall_run = 0;
  int   last_stall_run = 0;
  int   rvalid_count = 0;
  int   issue_count = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_memread || mem_memwrite) begin
        issue_count++;
        checkOutput("issue_pulse_width", 32'(prev_issue), 32'h0);
        if (issue_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_issue: addr 0x%08h with nothing expected", mem_addr);
        end else begin
          issue_t e;
          e = issue_q.pop_front();
          checkOutput("issue_memread", 32'(mem_memread), 32'(e.rd));
          checkOutput("issue_memwrite", 32'(mem_memwrite), 32'(e.wr));
          checkOutput("issue_addr", mem_addr, e.addr);
          if (e.wr) checkOutput("issue_wdata", mem_wdata, e.wdata);
          checkOutput("issue_sign_mask", 32'(mem_sign_mask), 32'(e.mask));
          issue_cycle = cycle;
          cur_lat = e.lat;
        end
      end
      if (dbg_gnt) checkOutput("dbg_gnt_pulse_width", 32'(prev_gnt), 32'h0);
      if (cpu_memread || cpu_memwrite) begin
        if (cpu_stall) begin
          stall_run++;
        end else begin
          last_stall_run = stall_run;
          stall_run = 0;
          if (cpu_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_cpu_done: cpu_stall low with nothing expected");
          end else begin
            resp_t r;
            r = cpu_q.pop_front();
            if (r.is_read) checkOutput("cpu_rdata", cpu_rdata, r.rdata);
            checkOutput("cpu_latency", 32'(cycle - issue_cycle), 32'(cur_lat));
          end
        end
      end
      if (dbg_rvalid) begin
        rvalid_count++;
        if (dbg_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_dbg_rvalid: rdata 0x%08h with nothing expected", dbg_rdata);
        end else begin
          checkOutput("dbg_rdata", dbg_rdata, dbg_q.pop_front());
          checkOutput("dbg_latency", 32'(cycle - issue_cycle), 32'(cur_lat));
        end
      end
    end
    prev_issue = mem_memread || mem_memwrite;
    prev_gnt   = dbg_gnt;
  end

  // Drivers start and end just after a rising edge
  task automatic cpuDrive(input bit we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] mask);
    int n;
    cpu_memread   = !we;
    cpu_memwrite  = we;
    cpu_addr      = addr;
    cpu_wdata     = wdata;
    cpu_sign_mask = mask;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!cpu_stall) break;
    end
    if (n == 200) begin
      checks++;
      failures++;
      $display("[TB] FAIL cpu_wait_bound: cpu_stall still high after 200 cycles, required release");
    end
    @(posedge clk);
    #1;
    cpu_memread  = 1'b0;
    cpu_memwrite = 1'b0;
  endtask

  task automatic dbgDrive(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    dbg_req   = 1'b1;
    dbg_we    = we;
    dbg_addr  = addr;
    dbg_wdata = wdata;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (dbg_gnt) break;
    end
    if (n == 200) begin
      checks++;
      failures++;
      $display("[TB] FAIL dbg_gnt_bound: no dbg_gnt after 200 cycles, required a grant");
    end
    @(posedge clk);
    #1;
    dbg_req = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    for (n = 0; n < 300; n++) begin
      if (issue_q.size() == 0 && cpu_q.size() == 0 && dbg_q.size() == 0) break;
      @(posedge clk);
    end
    if (n == 300) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_bound: %0d issues %0d cpu %0d dbg still pending, required 0",
               issue_q.size(), cpu_q.size(), dbg_q.size());
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  // kind: 0 cpu read, 1 cpu write, 2 dbg read, 3 dbg write, 4 contention
  task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [31:0] addr2,
                               input logic [31:0] wdata, input logic [3:0] mask, input bit we2);
    bit dbg_first;
    case (kind)
      0, 1: begin
        modelServe(1'b0, kind == 1, addr, wdata, mask, 1'b0);
        cpuDrive(kind == 1, addr, wdata, mask);
      end
      2, 3: begin
        modelServe(1'b1, kind == 3, addr, wdata, mask, 1'b0);
        dbgDrive(kind == 3, addr, wdata);
      end
      default: begin
`ifdef DATA_MEM_ARB_RR_EN
        dbg_first = (model_last == 1'b0);
`else
        dbg_first = 1'b0;
`endif
        if (dbg_first) begin
          modelServe(1'b1, we2, addr2, ~wdata, mask, 1'b0);
          modelServe(1'b0, 1'b0, addr, wdata, mask, 1'b0);
        end else begin
          modelServe(1'b0, 1'b0, addr, wdata, mask, 1'b0);
          modelServe(1'b1, we2, addr2, ~wdata, mask, 1'b0);
        end
        fork
          cpuDrive(1'b0, addr, wdata, mask);
          dbgDrive(we2, addr2, ~wdata);
        join
      end
    endcase
    waitDrain();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_cpu_rdata"}, cpu_rdata, 32'h0);
    checkOutput({tag, "_cpu_stall"}, 32'(cpu_stall), 32'h0);
    checkOutput({tag, "_dbg_gnt"}, 32'(dbg_gnt), 32'h0);
    checkOutput({tag, "_dbg_rvalid"}, 32'(dbg_rvalid), 32'h0);
    checkOutput({tag, "_dbg_rdata"}, dbg_rdata, 32'h0);
    checkOutput({tag, "_mem_memread"}, 32'(mem_memread), 32'h0);
    checkOutput({tag, "_mem_memwrite"}, 32'(mem_memwrite), 32'h0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 32'h0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    checkOutput({tag, "_mem_sign_mask"}, 32'(mem_sign_mask), 32'h0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at 500000 ns, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rv_before;
    int is_before;
    reset = 1'b1;
    cpu_memread = 1'b0;
    cpu_memwrite = 1'b0;
    cpu_addr = 32'h0;
    cpu_wdata = 32'h0;
    cpu_sign_mask = 4'h0;
    dbg_req = 1'b0;
    dbg_we = 1'b0;
    dbg_addr = 32'h0;
    dbg_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] CPU load with one stall cycle");
    env_mem[32'h1004] = 32'h1234_5678;
    model_mem[32'h1004] = 32'h1234_5678;
    next_lat = 1;
    applyStimulus(0, 32'h1004, 32'h0, 32'h0, 4'b0111, 1'b0);
    checkOutput("cpu_stall_cycles", 32'(last_stall_run), 32'd3);

    $display("[TB] debug write then read back");
    rv_before = rvalid_count;
    applyStimulus(3, 32'h1010, 32'h0, 32'hA5A5_A5A5, 4'b0000, 1'b0);
    checkOutput("dbg_write_no_rvalid", 32'(rvalid_count - rv_before), 32'h0);
    next_lat = 3;
    applyStimulus(2, 32'h1010, 32'h0, 32'h0, 4'b0000, 1'b0);

    $display("[TB] simultaneous requests");
    applyStimulus(4, 32'h1004, 32'h1010, 32'h0BAD_F00D, 4'b0010, 1'b1);
    next_lat = 2;
    applyStimulus(1, 32'h1018, 32'h0, 32'h7777_1111, 4'b0111, 1'b0);
    applyStimulus(4, 32'h1018, 32'h1020, 32'h1357_9BDF, 4'b0101, 1'b0);

    $display("[TB] memory never stalls: timeout");
    dead = 1'b1;
    applyStimulus(0, 32'h1004, 32'h0, 32'h0, 4'b0111, 1'b0);
    applyStimulus(2, 32'h1010, 32'h0, 32'h0, 4'b0000, 1'b0);
    dead = 1'b0;
    next_lat = 1;
    applyStimulus(0, 32'h1004, 32'h0, 32'h0, 4'b0111, 1'b0);

    $display("[TB] reset during a debug read");
    next_lat = 6;
    rv_before = rvalid_count;
    modelServe(1'b1, 1'b0, 32'h1010, 32'h0, 4'b0000, 1'b1);
    dbgDrive(1'b0, 32'h1010, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkAllZero("midreset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_last = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("reset_no_rvalid", 32'(rvalid_count - rv_before), 32'h0);
    checkOutput("reset_issue_consumed", 32'(issue_q.size()), 32'h0);

    $display("[TB] back-to-back CPU loads");
    next_lat = 2;
    is_before = issue_count;
    modelServe(1'b0, 1'b0, 32'h1000, 32'h0, 4'b0111, 1'b0);
    modelServe(1'b0, 1'b0, 32'h1008, 32'h0, 4'b0111, 1'b0);
    cpuDrive(1'b0, 32'h1000, 32'h0, 4'b0111);
    cpuDrive(1'b0, 32'h1008, 32'h0, 4'b0111);
    waitDrain();
    checkOutput("back_to_back_issues", 32'(issue_count - is_before), 32'd2);

    $display("[TB] random traffic");
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      logic [31:0] a2;
      next_lat = int'($urandom_range(1, 4));
      a  = 32'h1000 + 32'(4 * $urandom_range(0, 7));
      a2 = 32'h1000 + 32'(4 * $urandom_range(0, 7));
      applyStimulus(int'($urandom_range(0, 4)), a, a2, $urandom, 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)));
    end

    checkOutput("final_issue_queue_empty", 32'(issue_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
